// File: rtl/pulpino_rst_fetch_ctrl.sv
// Board-level reset/boot sequencer for the pulpino SoC: conditions the button and fetch switch, then paces SoC reset release and fetch enable.
// Define PULPINO_RSTCTRL_AUTOFETCH_EN to ignore fetch_sw_i and go straight from DELAY to RUN.

module pulpino_rst_fetch_ctrl_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_filt
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [DW-1:0]          r_cnt;
    logic                   r_filt;
    logic                   w_sync;

    assign w_sync = r_sync[SYNC_STAGES-1];
    assign o_filt = r_filt;

    // Metastability chain for the asynchronous input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
        end
    end

    // The filtered value only follows a sync value that has disagreed with it for DEBOUNCE_CYCLES edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_filt <= 1'b0;
        end else if (w_sync != r_filt) begin
            if (r_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                r_filt <= w_sync;
                r_cnt  <= '0;
            end else begin
                r_cnt  <= r_cnt + 1'b1;
            end
        end else begin
            r_cnt <= '0;
        end
    end
endmodule

module pulpino_rst_fetch_ctrl #(
    parameter int SYNC_STAGES        = 2,
    parameter int DEBOUNCE_CYCLES    = 65536,
    parameter int RST_HOLD_CYCLES    = 1024,
    parameter int FETCH_DELAY_CYCLES = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_rst_i,
    input  logic       fetch_sw_i,
    output logic       soc_rst_n_o,
    output logic       fetch_enable_o,
    output logic [1:0] state_o,
    output logic       busy_o
);
    localparam int CNT_MAX = (RST_HOLD_CYCLES > FETCH_DELAY_CYCLES) ? RST_HOLD_CYCLES : FETCH_DELAY_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_DELAY = 2'd1,
        ST_IDLE  = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_btn_filt;
    logic          r_btn_filt_d;
    logic          w_btn_edge;
    logic          w_soc_rst_n;
    logic          w_fetch;
    logic          w_busy;

    pulpino_rst_fetch_ctrl_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_deb (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (btn_rst_i),
        .o_filt  (w_btn_filt)
    );

`ifdef PULPINO_RSTCTRL_AUTOFETCH_EN
    logic w_unused_sw;
    assign w_unused_sw = fetch_sw_i;
`else
    logic w_sw_filt;
    pulpino_rst_fetch_ctrl_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sw_deb (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (fetch_sw_i),
        .o_filt  (w_sw_filt)
    );
`endif

    // A held button must not re-trigger, so only the filtered rising edge counts
    assign w_btn_edge = w_btn_filt & ~r_btn_filt_d;

    // State, shared phase counter and button edge history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_HOLD;
            r_cnt        <= '0;
            r_btn_filt_d <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_btn_filt_d <= w_btn_filt;
        end
    end

    // Next-state logic; a button edge overrides every other transition
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (w_btn_edge) begin
            w_state_nxt = ST_HOLD;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    if (r_cnt == CW'(RST_HOLD_CYCLES - 1)) begin
                        w_state_nxt = ST_DELAY;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt + 1'b1;
                    end
                end
                ST_DELAY: begin
                    if (r_cnt == CW'(FETCH_DELAY_CYCLES - 1)) begin
`ifdef PULPINO_RSTCTRL_AUTOFETCH_EN
                        w_state_nxt = ST_RUN;
`else
                        w_state_nxt = ST_IDLE;
`endif
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
`ifdef PULPINO_RSTCTRL_AUTOFETCH_EN
                    w_state_nxt = ST_RUN;
`else
                    if (w_sw_filt) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
`endif
                end
                ST_RUN: begin
`ifdef PULPINO_RSTCTRL_AUTOFETCH_EN
                    w_state_nxt = ST_RUN;
`else
                    if (!w_sw_filt) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
`endif
                end
                default: begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Outputs decoded from the registered state only
    always_comb begin
        w_soc_rst_n = 1'b1;
        w_fetch     = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            ST_HOLD: begin
                w_soc_rst_n = 1'b0;
                w_busy      = 1'b1;
            end
            ST_DELAY: begin
                w_busy      = 1'b1;
            end
            ST_IDLE: begin
                w_fetch     = 1'b0;
            end
            ST_RUN: begin
                w_fetch     = 1'b1;
            end
            default: begin
                w_soc_rst_n = 1'b0;
                w_busy      = 1'b1;
            end
        endcase
    end

    assign soc_rst_n_o    = w_soc_rst_n;
    assign fetch_enable_o = w_fetch;
    assign busy_o         = w_busy;
    assign state_o        = r_state;
endmodule

// File: tb/tb_pulpino_rst_fetch_ctrl.sv
// Randomised bench for pulpino_rst_fetch_ctrl: a cycle-level reference model queues expected state changes,
// and a monitor compares every observed state change against that queue.
`timescale 1ns/1ps

module tb_pulpino_rst_fetch_ctrl;
    localparam int SYNC = 2;
    localparam int DEB  = 8;
    localparam int HOLD = 16;
    localparam int FDLY = 4;
`ifdef PULPINO_RSTCTRL_AUTOFETCH_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       btn_rst_i;
    logic       fetch_sw_i;
    logic       soc_rst_n_o;
    logic       fetch_enable_o;
    logic [1:0] state_o;
    logic       busy_o;

    pulpino_rst_fetch_ctrl #(
        .SYNC_STAGES        (SYNC),
        .DEBOUNCE_CYCLES    (DEB),
        .RST_HOLD_CYCLES    (HOLD),
        .FETCH_DELAY_CYCLES (FDLY)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .btn_rst_i      (btn_rst_i),
        .fetch_sw_i     (fetch_sw_i),
        .soc_rst_n_o    (soc_rst_n_o),
        .fetch_enable_o (fetch_enable_o),
        .state_o        (state_o),
        .busy_o         (busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int cyc;
        int st;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp  = 0;
    int  n_fail = 0;
    int  cyc    = 0;
    bit  mon_en = 1'b0;
    int  prev_state = 0;

    // reference model variables (state numbers: 0 HOLD, 1 DELAY, 2 IDLE, 3 RUN)
    int  m_st;
    int  m_entry;
    bit  btn_q[$];
    bit  sw_q[$];
    bit  btn_filt, btn_prev, sw_filt;
    int  btn_run, sw_run;

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_entry = 0; cyc = 0;
        btn_q.delete(); sw_q.delete();
        for (int i = 0; i < SYNC; i++) begin
            btn_q.push_back(1'b0);
            sw_q.push_back(1'b0);
        end
        btn_filt = 1'b0; btn_prev = 1'b0; sw_filt = 1'b0;
        btn_run = 0; sw_run = 0;
    endtask

    task automatic deb(input bit s, inout bit filt, inout int run);
        if (s != filt) begin
            run++;
            if (run == DEB) begin
                filt = s;
                run  = 0;
            end
        end else begin
            run = 0;
        end
    endtask

    // One clock edge of the specification's behaviour, using the inputs held across that edge
    task automatic model_edge(input bit b, input bit s);
        int nst;
        bit pressed;
        bit sb, ss;
        cyc++;
        nst     = m_st;
        pressed = btn_filt && !btn_prev;
        if (pressed) begin
            nst = 0;
        end else begin
            case (m_st)
                0: if (cyc - m_entry == HOLD) nst = 1;
                1: if (cyc - m_entry == FDLY) nst = AUTO ? 3 : 2;
                2: if (AUTO || sw_filt) nst = 3;
                3: if (!AUTO && !sw_filt) nst = 2;
                default: nst = 0;
            endcase
        end
        if (pressed || nst != m_st) m_entry = cyc;
        if (nst != m_st) exp_q.push_back('{cyc: cyc, st: nst});
        m_st = nst;
        sb = btn_q.pop_front(); btn_q.push_back(b);
        ss = sw_q.pop_front();  sw_q.push_back(s);
        btn_prev = btn_filt;
        deb(sb, btn_filt, btn_run);
        deb(ss, sw_filt, sw_run);
    endtask

    // Drive inputs at the falling edge, model the rising edge, return at the next falling edge
    task automatic run(input int n, input bit b, input bit s);
        for (int i = 0; i < n; i++) begin
            btn_rst_i  = b;
            fetch_sw_i = s;
            @(posedge clk);
            model_edge(b, s);
            @(negedge clk);
        end
    endtask

    task automatic drain_check(input string name);
        #1;
        chk(name, exp_q.size(), 0);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_soc_rst_n_o"}, soc_rst_n_o, 0);
        chk({tag, "_fetch_enable_o"}, fetch_enable_o, 0);
        chk({tag, "_state_o"}, state_o, 0);
        chk({tag, "_busy_o"}, busy_o, 1);
    endtask

    // Monitor: every state change the DUT presents must match the next queued expectation
    always @(negedge clk) begin : monitor
        ev_t ev;
        if (mon_en) begin
            if (int'(state_o) != prev_state) begin
                chk("event_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    ev = exp_q.pop_front();
                    chk("event_cycle", cyc, ev.cyc);
                    chk("state_o", state_o, ev.st);
                    chk("soc_rst_n_o", soc_rst_n_o, int'(ev.st != 0));
                    chk("fetch_enable_o", fetch_enable_o, int'(ev.st == 3));
                    chk("busy_o", busy_o, int'(ev.st <= 1));
                end
                prev_state = int'(state_o);
            end
        end else begin
            prev_state = int'(state_o);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; btn_rst_i = 1'b0; fetch_sw_i = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        chk_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1; mon_en = 1'b1;
        run(40, 1'b0, 1'b1);
        drain_check("boot_events");

        // button glitches shorter than the debounce window
        for (int i = 0; i < 12; i++) begin
            run($urandom_range(1, DEB - 1), 1'b1, 1'b1);
            run($urandom_range(2, 6), 1'b0, 1'b1);
        end
        drain_check("glitch_events");

        // long press, then random press / re-press patterns
        run(20, 1'b1, 1'b1);
        run(40, 1'b0, 1'b1);
        drain_check("long_press_events");
        for (int i = 0; i < 3; i++) begin
            run($urandom_range(8, 14), 1'b1, 1'b1);
            run($urandom_range(8, 14), 1'b0, 1'b1);
        end
        run(40, 1'b0, 1'b1);
        drain_check("repress_events");

        // fetch switch glitches and real drops
        for (int i = 0; i < 6; i++) begin
            run($urandom_range(1, DEB - 1), 1'b0, 1'b0);
            run($urandom_range(2, 6), 1'b0, 1'b1);
        end
        run($urandom_range(10, 14), 1'b0, 1'b0);
        run(20, 1'b0, 1'b1);
        run($urandom_range(10, 14), 1'b0, 1'b0);
        run(20, 1'b0, 1'b1);
        drain_check("switch_events");

        // board reset asserted mid-DELAY
        run(10, 1'b1, 1'b1);
        for (int k = 0; k < 100 && m_st != 1; k++) run(1, 1'b0, 1'b1);
        run(1, 1'b0, 1'b1);
        #1;
        chk("state_before_async_rst", state_o, 1);
        #1;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk_reset_values("async_rst");
        chk("events_before_async_rst", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        mon_en = 1'b1;
        run(40, 1'b0, 1'b1);
        drain_check("reboot_events");

        // random mix of button and switch activity
        for (int i = 0; i < 150; i++) begin
            run($urandom_range(1, 12), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
        end
        run(60, 1'b0, 1'b1);
        drain_check("random_events");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
